// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } ccff_state_t;

  // Value the shift register takes on reset and shifts in from the LSB side.
  localparam logic CCFF_SHREG_RST_BIT = 1'b0;

  function automatic int ccff_bits_per_word(input int word_w);
    return word_w;
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_piso.sv
// Parallel-load, serial-out shift register; MSB leaves first on so.
module ccff_piso
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              so
);

  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {shreg_q[WORD_W-2:0], CCFF_SHREG_RST_BIT};
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      shreg_q <= {WORD_W{CCFF_SHREG_RST_BIT}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign so = shreg_q[WORD_W-1];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds a word-wide bitstream into the configuration chain head, one
// prog_en pulse per chain bit, and signals done after the last bit.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic              done
);

  localparam int                 IDX_W     = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0]   WORD_BITS = IDX_W'(ccff_bits_per_word(WORD_W));
  localparam logic [CNT_W-1:0]   LEN_C     = CNT_W'(CHAIN_LEN);

  ccff_state_t      state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             head_q, head_d;
  logic             load, shift, so;

  ccff_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .CK    (CK),
    .RST   (RST),
    .load  (load),
    .shift (shift),
    .din   (din),
    .so    (so)
  );

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    bit_idx_d   = bit_idx_q;
    head_d      = head_q;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bits_left_d = LEN_C;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (din_valid) begin
          load      = 1'b1;
          bit_idx_d = WORD_BITS;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift       = 1'b1;
        head_d      = so;
        bits_left_d = bits_left_q - CNT_W'(1);
        bit_idx_d   = bit_idx_q - IDX_W'(1);
        // Chain completion wins over word exhaustion: drops the unused low bits of a partial word.
        if (bits_left_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (bit_idx_q == IDX_W'(1)) begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      bit_idx_q   <= '0;
      head_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      bit_idx_q   <= bit_idx_d;
      head_q      <= head_d;
    end
  end

  assign din_ready = (state_q == LOAD);
  assign prog_en   = (state_q == SHIFT);
  assign busy      = (state_q == LOAD) || (state_q == SHIFT);
  assign done      = (state_q == DONE);
  // head_q keeps the last shifted bit visible while the chain is not stepping.
  assign ccff_head = prog_en ? so : head_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: three chain lengths, randomized sources,
// a behavioural bitstream/chain model and a few literal pins.
module tb_ccff_bitstream_loader;

  localparam int W = 8;

  logic         CK  = 1'b0;
  logic         RST = 1'b1;
  logic         start_v     [3];
  logic         din_valid_v [3];
  logic [W-1:0] din_v       [3];
  logic         din_ready_v [3];
  logic         prog_en_v   [3];
  logic         busy_v      [3];
  logic         done_v      [3];
  logic         head_v      [3];

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(16)) u0 (
    .CK(CK), .RST(RST), .start(start_v[0]), .din(din_v[0]), .din_valid(din_valid_v[0]),
    .din_ready(din_ready_v[0]), .ccff_head(head_v[0]), .prog_en(prog_en_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(20)) u1 (
    .CK(CK), .RST(RST), .start(start_v[1]), .din(din_v[1]), .din_valid(din_valid_v[1]),
    .din_ready(din_ready_v[1]), .ccff_head(head_v[1]), .prog_en(prog_en_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(1)) u2 (
    .CK(CK), .RST(RST), .start(start_v[2]), .din(din_v[2]), .din_valid(din_valid_v[2]),
    .din_ready(din_ready_v[2]), .ccff_head(head_v[2]), .prog_en(prog_en_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  function automatic int len_of(input int k);
    case (k)
      0:       return 16;
      1:       return 20;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int k);
    return (64'h1 << len_of(k)) - 64'h1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: expected bit list per pass plus DFFR-style chains.
  bit          m_active [3];
  bit          m_done   [3];
  bit          m_last   [3];
  int          m_pend   [3];
  int          m_pushed [3];
  int          m_pulses [3];
  int          m_rd     [3];
  logic [63:0] exp_bits  [3];
  logic [63:0] exp_chain [3];
  logic [63:0] chain_v   [3];
  int          act_pulses[3];

  always @(negedge CK) begin
    bit e_pe, e_rdy, n_active, n_done;
    int nb, n_pend, n_pulses, n_pushed;
    for (int k = 0; k < 3; k++) begin
      if (RST) begin
        m_active[k] = 1'b0; m_done[k] = 1'b0; m_last[k] = 1'b0;
        m_pend[k] = 0; m_pushed[k] = 0; m_pulses[k] = 0; m_rd[k] = 0;
      end else begin
        e_pe  = (m_pend[k] > 0);
        e_rdy = m_active[k] && !e_pe;
        chk("din_ready", k, 64'(din_ready_v[k]), 64'(e_rdy));
        chk("prog_en",   k, 64'(prog_en_v[k]),   64'(e_pe));
        chk("busy",      k, 64'(busy_v[k]),      64'(m_active[k]));
        chk("done",      k, 64'(done_v[k]),      64'(m_done[k]));
        if (e_pe) begin
          m_last[k] = exp_bits[k][m_rd[k]];
          m_rd[k]++;
        end
        chk("ccff_head", k, 64'(head_v[k]), 64'(m_last[k]));
        if (prog_en_v[k]) begin
          chain_v[k] = {chain_v[k][62:0], head_v[k]};
          act_pulses[k]++;
        end
        if (m_done[k]) chk("chain", k, chain_v[k] & mask(k), exp_chain[k] & mask(k));

        n_active = m_active[k]; n_done = 1'b0; n_pend = m_pend[k];
        n_pulses = m_pulses[k]; n_pushed = m_pushed[k];
        if (e_pe) begin
          n_pend--;
          n_pulses++;
          if (n_pulses == len_of(k)) begin
            n_active = 1'b0;
            n_done   = 1'b1;
          end
        end else if (e_rdy && din_valid_v[k]) begin
          nb = len_of(k) - m_pushed[k];
          if (nb > W) nb = W;
          for (int i = 0; i < nb; i++) begin
            exp_bits[k][m_pushed[k] + i] = din_v[k][W-1-i];
            exp_chain[k] = {exp_chain[k][62:0], din_v[k][W-1-i]};
          end
          n_pushed += nb;
          n_pend = nb;
        end
        if (!m_active[k] && !m_done[k] && start_v[k]) begin
          n_active = 1'b1; n_pushed = 0; n_pulses = 0; m_rd[k] = 0;
        end
        m_active[k] = n_active; m_done[k] = n_done; m_pend[k] = n_pend;
        m_pulses[k] = n_pulses; m_pushed[k] = n_pushed;
      end
    end
  end

  logic [W-1:0] wbuf [8];
  int           wn = 0;

  task automatic run_pass(input int k, input int init_stall, input int stall_pct,
                          input bit junk, output int cyc);
    int c, wi;
    bit seen;
    act_pulses[k] = 0;
    @(posedge CK); #1;
    start_v[k] = 1'b1; din_valid_v[k] = 1'b0;
    c = 0; wi = 0; seen = 1'b0;
    while (!seen && c < 3000) begin
      @(negedge CK);
      if (done_v[k]) begin
        seen = 1'b1;
      end else begin
        if (din_ready_v[k] && din_valid_v[k]) wi++;
        @(posedge CK); #1;
        c++;
        start_v[k]     = junk && ($urandom_range(0, 3) == 0);
        din_valid_v[k] = (c > init_stall) && ($urandom_range(0, 99) >= stall_pct);
        din_v[k]       = (wi < wn) ? wbuf[wi] : W'($urandom);
      end
    end
    start_v[k] = 1'b0; din_valid_v[k] = 1'b0;
    cyc = c;
    chk("done_seen", k, 64'(seen), 64'(1));
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; din_valid_v[k] = 1'b0; din_v[k] = '0;
      chain_v[k] = '0; exp_chain[k] = '0; exp_bits[k] = '0; act_pulses[k] = 0;
    end
    repeat (3) @(posedge CK);
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_outs", k, 64'({din_ready_v[k], prog_en_v[k], busy_v[k], done_v[k], head_v[k]}), 64'(0));
    @(negedge CK); #2 RST = 1'b0;

    // Basic pass: 0xA5, 0x3C into a 16-bit chain.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wn = 2;
    run_pass(0, 0, 0, 1'b0, cyc);
    chk("basic_done_cycle", 0, 64'(cyc), 64'(19));
    chk("basic_chain", 0, chain_v[0] & mask(0), 64'hA53C);
    chk("basic_pulses", 0, 64'(act_pulses[0]), 64'(16));

    // Partial last word: 0xF7 contributes only its upper nibble.
    wbuf[2] = 8'hF7; wn = 3;
    run_pass(1, 0, 0, 1'b0, cyc);
    chk("partial_chain", 1, chain_v[1] & mask(1), 64'hA53CF);
    chk("partial_tail", 1, chain_v[1] & 64'hF, 64'hF);
    chk("partial_pulses", 1, 64'(act_pulses[1]), 64'(20));

    // Source stalls for 5 cycles in LOAD, random words afterwards.
    wn = 0;
    run_pass(1, 5, 0, 1'b0, cyc);
    chk("stall_pulses", 1, 64'(act_pulses[1]), 64'(20));
    chk("stall_done_cycle", 1, 64'(cyc), 64'(5 + 2 * 9 + 5 + 1));

    // Junk start / valid pulses during the pass.
    run_pass(0, 0, 30, 1'b1, cyc);
    chk("junk_pulses", 0, 64'(act_pulses[0]), 64'(16));

    // Minimum chain.
    wbuf[0] = 8'h80; wn = 1;
    run_pass(2, 0, 0, 1'b0, cyc);
    chk("min_chain", 2, chain_v[2] & 64'h1, 64'h1);
    chk("min_pulses", 2, 64'(act_pulses[2]), 64'(1));
    chk("min_done_cycle", 2, 64'(cyc), 64'(3));

    // Randomized passes across all chain lengths.
    wn = 0;
    for (int n = 0; n < 8; n++) begin
      int k;
      k = $urandom_range(0, 2);
      run_pass(k, $urandom_range(0, 3), $urandom_range(0, 50), 1'($urandom_range(0, 1)), cyc);
      chk("rand_pulses", k, 64'(act_pulses[k]), 64'(len_of(k)));
    end

    // Reset in the middle of a pass, then a fresh pass.
    act_pulses[1] = 0;
    @(posedge CK); #1;
    start_v[1] = 1'b1; din_valid_v[1] = 1'b1; din_v[1] = W'($urandom);
    @(posedge CK); #1;
    start_v[1] = 1'b0;
    for (int c = 0; c < 200 && act_pulses[1] < 5; c++) @(negedge CK);
    chk("pre_reset_pulses", 1, 64'(act_pulses[1] >= 5), 64'(1));
    #2 RST = 1'b1;
    din_valid_v[1] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk("async_reset_outs", k, 64'({din_ready_v[k], prog_en_v[k], busy_v[k], done_v[k], head_v[k]}), 64'(0));
    @(negedge CK); #2 RST = 1'b0;
    run_pass(1, 0, 20, 1'b0, cyc);
    chk("post_reset_pulses", 1, 64'(act_pulses[1]), 64'(20));

    repeat (3) @(posedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
